oai22_vec_pipe: RTL and testbench

// - Parametrised, pipelined successor to the single-bit OAI22 cell function.
// - Computes WIDTH lanes of ZN = ~((A1|A2)&(B1|B2)), or AOI22 ZN = ~((A1&A2)|(B1&B2)) when MODE=1.
// - Carries results through PIPE_DEPTH valid/ready register stages with backpressure.
// - Counts output-bit toggles per accepted word, for switching-activity characterisation of the cell library.

---
 rtl/oai22_pkg.sv | 31 +++
 rtl/oai22_vec_pipe_if.sv | 30 +++
 rtl/oai22_pipe_stage.sv | 32 +++
 rtl/oai22_vec_pipe.sv | 99 +++++++++
 tb/tb_oai22_vec_pipe.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oai22_pkg.sv
// Shared constants and lane-function helpers for the OAI22/AOI22 vector pipe.
// Helpers work on MAX_W-bit words; callers zero-extend and slice to their width.
package oai22_pkg;

    localparam logic MODE_OAI22 = 1'b0;
    localparam logic MODE_AOI22 = 1'b1;

    localparam int MAX_W = 64;
    localparam int PC_W  = $clog2(MAX_W + 1);

    function automatic logic [MAX_W-1:0] oai22_eval(
        input logic [MAX_W-1:0] a1,
        input logic [MAX_W-1:0] a2,
        input logic [MAX_W-1:0] b1,
        input logic [MAX_W-1:0] b2,
        input logic             mode
    );
        if (mode == MODE_AOI22)
            return ~((a1 & a2) | (b1 & b2));
        return ~((a1 | a2) & (b1 | b2));
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [MAX_W-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_W; i++)
            n = n + PC_W'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/oai22_vec_pipe_if.sv
// Input word, output word and toggle-counter signals of the vector pipe.
// The producer/consumer side uses master; the pipe itself uses slave.
interface oai22_vec_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] A2;
    logic [WIDTH-1:0] B1;
    logic [WIDTH-1:0] B2;
    logic             MODE;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] ZN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             CLR;
    logic [CNT_W-1:0] TOGGLE_CNT;

    modport master (
        output A1, A2, B1, B2, MODE, IN_VALID, OUT_READY, CLR,
        input  IN_READY, ZN, OUT_VALID, TOGGLE_CNT
    );

    modport slave (
        input  A1, A2, B1, B2, MODE, IN_VALID, OUT_READY, CLR,
        output IN_READY, ZN, OUT_VALID, TOGGLE_CNT
    );

endinterface

// File: rtl/oai22_pipe_stage.sv
// One valid/data pipeline register; loads from upstream when allowed to advance.
// Data only loads with a valid word so an emptied stage keeps its last value.
module oai22_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_adv,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            if (i_valid)
                r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/oai22_vec_pipe.sv
// WIDTH-lane OAI22/AOI22 evaluator feeding a PIPE_DEPTH-stage valid/ready pipe,
// with a saturating counter of output-bit toggles between accepted words.
module oai22_vec_pipe
    import oai22_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic            CK,
    input  logic            RST,
    oai22_vec_pipe_if.slave bus
);

    localparam int SW = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SW-1:0] CMAX = {{(SW - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [MAX_W-1:0]  w_eval;
    logic [PIPE_DEPTH:0] w_adv;
    logic [PIPE_DEPTH-1:0] w_sv;
    logic [WIDTH-1:0]  w_sd [PIPE_DEPTH];
    logic [WIDTH-1:0]  w_zn;
    logic              w_out_valid;
    logic              w_hs_out;
    logic [PC_W-1:0]   w_delta;
    logic [SW-1:0]     w_sum;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [WIDTH-1:0]  r_last;
    logic [CNT_W-1:0]  r_cnt;

    assign w_eval = oai22_eval(MAX_W'(bus.A1), MAX_W'(bus.A2),
                               MAX_W'(bus.B1), MAX_W'(bus.B2), bus.MODE);

    // Ready ripples back from the consumer through every stage.
    always_comb begin
        w_adv = '0;
        w_adv[PIPE_DEPTH] = bus.OUT_READY;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--)
            w_adv[k] = ~w_sv[k] | w_adv[k+1];
    end

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            oai22_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .i_clk   (CK),
                .i_rst   (RST),
                .i_adv   (w_adv[0]),
                .i_valid (bus.IN_VALID),
                .i_data  (w_eval[WIDTH-1:0]),
                .o_valid (w_sv[0]),
                .o_data  (w_sd[0])
            );
        end else begin : g_body
            oai22_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .i_clk   (CK),
                .i_rst   (RST),
                .i_adv   (w_adv[k]),
                .i_valid (w_sv[k-1]),
                .i_data  (w_sd[k-1]),
                .o_valid (w_sv[k]),
                .o_data  (w_sd[k])
            );
        end
    end

    assign w_zn        = w_sd[PIPE_DEPTH-1];
    assign w_out_valid = w_sv[PIPE_DEPTH-1];
    assign w_hs_out    = w_out_valid & bus.OUT_READY;

    assign w_delta = popcount(MAX_W'(w_zn ^ r_last));
    assign w_sum   = SW'(r_cnt) + SW'(w_delta);

    always_comb begin
        w_cnt_next = w_sum[CNT_W-1:0];
        if (w_sum > CMAX)
            w_cnt_next = {CNT_W{1'b1}};
    end

    // CLR wins over the count but never blocks the last-word update.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_last <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_hs_out)
                r_last <= w_zn;
            if (bus.CLR)
                r_cnt <= '0;
            else if (w_hs_out)
                r_cnt <= w_cnt_next;
        end
    end

    assign bus.IN_READY   = w_adv[0];
    assign bus.ZN         = w_zn;
    assign bus.OUT_VALID  = w_out_valid;
    assign bus.TOGGLE_CNT = r_cnt;

endmodule

// File: tb/tb_oai22_vec_pipe.sv
// Randomised and directed bench for oai22_vec_pipe against a lane-level model.
// A second instance with a 4-bit counter covers saturation.
module tb_oai22_vec_pipe;

    localparam int PD = 2;

    logic CK;
    logic RST;

    oai22_vec_pipe_if #(.WIDTH(8), .CNT_W(16)) bus1 ();
    oai22_vec_pipe_if #(.WIDTH(8), .CNT_W(4))  bus2 ();

    oai22_vec_pipe #(.WIDTH(8), .PIPE_DEPTH(PD), .CNT_W(16)) dut1 (
        .CK  (CK),
        .RST (RST),
        .bus (bus1)
    );

    oai22_vec_pipe #(.WIDTH(8), .PIPE_DEPTH(PD), .CNT_W(4)) dut2 (
        .CK  (CK),
        .RST (RST),
        .bus (bus2)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] q_a1[$], q_a2[$], q_b1[$], q_b2[$];
    logic       q_md[$];
    logic [7:0] got[$];
    bit         dropped;
    int         stall_acc;
    bit         zn_moved;

    function automatic logic [7:0] ref_zn(input logic [7:0] a1, input logic [7:0] a2,
                                          input logic [7:0] b1, input logic [7:0] b2,
                                          input logic md);
        logic [7:0] z;
        for (int i = 0; i < 8; i++) begin
            int sa, sb;
            if (!md) begin
                sa = int'(a1[i]) + int'(a2[i]);
                sb = int'(b1[i]) + int'(b2[i]);
                z[i] = !(sa > 0 && sb > 0);
            end else begin
                sa = int'(a1[i]) * int'(a2[i]);
                sb = int'(b1[i]) * int'(b2[i]);
                z[i] = (sa + sb) == 0;
            end
        end
        return z;
    endfunction

    function automatic int ham(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++)
            if (a[i] != b[i]) n++;
        return n;
    endfunction

    function automatic logic [7:0] exp_word(input int i);
        return ref_zn(q_a1[i], q_a2[i], q_b1[i], q_b2[i], q_md[i]);
    endfunction

    task automatic clear_q();
        q_a1.delete(); q_a2.delete(); q_b1.delete(); q_b2.delete(); q_md.delete();
    endtask

    task automatic push(input logic [7:0] a1, input logic [7:0] a2,
                        input logic [7:0] b1, input logic [7:0] b2, input logic md);
        q_a1.push_back(a1); q_a2.push_back(a2);
        q_b1.push_back(b1); q_b2.push_back(b2); q_md.push_back(md);
    endtask

    // kind 0: always ready, 1: ready low in cycles 3..7, 2: random ready
    task automatic run_stream(input int kind);
        int idx, cyc;
        bit hs, holding;
        logic [7:0] held;
        idx = 0; cyc = 0; holding = 0; held = '0;
        got.delete(); dropped = 0; stall_acc = 0; zn_moved = 0;
        while (got.size() < q_a1.size() && cyc < 500) begin
            bus1.IN_VALID = (idx < q_a1.size());
            if (idx < q_a1.size()) begin
                bus1.A1 = q_a1[idx]; bus1.A2 = q_a2[idx];
                bus1.B1 = q_b1[idx]; bus1.B2 = q_b2[idx];
                bus1.MODE = q_md[idx];
            end
            case (kind)
                1:       bus1.OUT_READY = !(cyc >= 3 && cyc <= 7);
                2:       bus1.OUT_READY = ($urandom_range(0, 3) != 0);
                default: bus1.OUT_READY = 1'b1;
            endcase
            #1;
            if (bus1.IN_VALID && !bus1.IN_READY) dropped = 1;
            if (holding && bus1.ZN !== held) zn_moved = 1;
            holding = bus1.OUT_VALID && !bus1.OUT_READY;
            held = bus1.ZN;
            if (bus1.OUT_VALID && bus1.OUT_READY) got.push_back(bus1.ZN);
            hs = bus1.IN_VALID && bus1.IN_READY;
            if (hs && !bus1.OUT_READY) stall_acc++;
            @(posedge CK); #1;
            if (hs) idx++;
            cyc++;
        end
        bus1.IN_VALID  = 1'b0;
        bus1.OUT_READY = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CK);
        #1;
        n_checks++;
        if (bus1.OUT_VALID !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus1.OUT_VALID);
        end
        n_checks++;
        if (bus1.TOGGLE_CNT !== 16'd0) begin
            n_err++; $display("FAIL reset_cnt got=%0d exp=0", bus1.TOGGLE_CNT);
        end
        RST = 1'b0;
        @(posedge CK); #1;
        n_checks++;
        if (bus1.IN_READY !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus1.IN_READY);
        end
        n_checks++;
        if (bus2.TOGGLE_CNT !== 4'd0 || bus2.OUT_VALID !== 1'b0) begin
            n_err++; $display("FAIL reset_dut2 got cnt=%0d ov=%b exp 0/0",
                              bus2.TOGGLE_CNT, bus2.OUT_VALID);
        end
    endtask

    task automatic test_truth(input logic [7:0] a1, input logic [7:0] a2,
                              input logic [7:0] b1, input logic [7:0] b2,
                              input logic md, input logic [7:0] want);
        bus1.A1 = a1; bus1.A2 = a2; bus1.B1 = b1; bus1.B2 = b2; bus1.MODE = md;
        bus1.IN_VALID = 1'b1; bus1.OUT_READY = 1'b1;
        @(posedge CK); #1;
        bus1.IN_VALID = 1'b0;
        for (int k = 0; k < PD - 1; k++) begin
            n_checks++;
            if (bus1.OUT_VALID !== 1'b0) begin
                n_err++; $display("FAIL latency_early k=%0d got ov=%b exp=0", k, bus1.OUT_VALID);
            end
            @(posedge CK); #1;
        end
        n_checks++;
        if (bus1.OUT_VALID !== 1'b1 || bus1.ZN !== want) begin
            n_err++; $display("FAIL truth_mode%0d got ov=%b zn=%h exp ov=1 zn=%h",
                              md, bus1.OUT_VALID, bus1.ZN, want);
        end
        @(posedge CK); #1;
    endtask

    task automatic test_sweep();
        logic [7:0] w1, w2, w3, w4;
        clear_q();
        for (int m = 0; m < 2; m++)
            for (int j = 0; j < 2; j++) begin
                for (int i = 0; i < 8; i++) begin
                    int c;
                    c = (i + 8 * j) % 16;
                    w1[i] = c[0]; w2[i] = c[1]; w3[i] = c[2]; w4[i] = c[3];
                end
                push(w1, w2, w3, w4, m[0]);
            end
        run_stream(0);
        for (int i = 0; i < q_a1.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_word(i)) begin
                n_err++; $display("FAIL sweep word=%0d got=%h exp=%h",
                                  i, (i < got.size()) ? got[i] : 8'hxx, exp_word(i));
            end
        end
    endtask

    task automatic test_backpressure();
        clear_q();
        for (int i = 0; i < 10; i++)
            push(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)));
        run_stream(1);
        n_checks++;
        if (got.size() != 10) begin
            n_err++; $display("FAIL bp_count got=%0d exp=10", got.size());
        end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_word(i)) begin
                n_err++; $display("FAIL bp_word%0d got=%h exp=%h", i, got[i], exp_word(i));
            end
        end
        n_checks++;
        if (!dropped || stall_acc > PD) begin
            n_err++; $display("FAIL bp_in_ready dropped=%0b stall_acc=%0d exp 1 and <=%0d",
                              dropped, stall_acc, PD);
        end
        n_checks++;
        if (zn_moved) begin
            n_err++; $display("FAIL bp_zn_stable got moved=1 exp=0");
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        clear_q();
        for (int i = 0; i < 40; i++)
            push(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)));
        run_stream(2);
        bad = 0;
        n_checks++;
        if (got.size() != 40) begin
            n_err++; $display("FAIL b2b_count got=%0d exp=40", got.size());
        end
        for (int i = 0; i < 40 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_word(i)) begin
                n_err++; bad++;
                if (bad < 4) $display("FAIL b2b_word%0d got=%h exp=%h", i, got[i], exp_word(i));
            end
        end
    endtask

    task automatic wait_out1(input string tag);
        for (int k = 0; k < 10 && !bus1.OUT_VALID; k++) begin
            @(posedge CK); #1;
        end
        n_checks++;
        if (!bus1.OUT_VALID) begin
            n_err++; $display("FAIL %s_timeout got ov=0 exp=1", tag);
        end
    endtask

    task automatic test_toggle_clr();
        int exp_cnt;
        logic [7:0] last;
        RST = 1'b1;
        @(posedge CK); #1;
        RST = 1'b0;
        clear_q();
        push(8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0);
        push(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        push(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        push(8'hF0, 8'h00, 8'hF0, 8'h00, 1'b0);
        run_stream(0);
        exp_cnt = 0; last = 8'h00;
        for (int i = 0; i < 4; i++) begin
            exp_cnt += ham(last, exp_word(i));
            last = exp_word(i);
        end
        n_checks++;
        if (bus1.TOGGLE_CNT !== 16'(exp_cnt)) begin
            n_err++; $display("FAIL toggle_cnt got=%0d exp=%0d", bus1.TOGGLE_CNT, exp_cnt);
        end
        bus1.A1 = 8'hFF; bus1.A2 = 8'h00; bus1.B1 = 8'hFF; bus1.B2 = 8'h00;
        bus1.MODE = 1'b0; bus1.IN_VALID = 1'b1;
        @(posedge CK); #1;
        bus1.IN_VALID = 1'b0;
        wait_out1("clr");
        bus1.CLR = 1'b1;
        @(posedge CK); #1;
        bus1.CLR = 1'b0;
        n_checks++;
        if (bus1.TOGGLE_CNT !== 16'd0) begin
            n_err++; $display("FAIL clr_cnt got=%0d exp=0", bus1.TOGGLE_CNT);
        end
        last = ref_zn(8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0);
        bus1.A1 = 8'h00; bus1.B1 = 8'h00; bus1.IN_VALID = 1'b1;
        @(posedge CK); #1;
        bus1.IN_VALID = 1'b0;
        wait_out1("after_clr");
        @(posedge CK); #1;
        exp_cnt = ham(last, ref_zn(8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        n_checks++;
        if (bus1.TOGGLE_CNT !== 16'(exp_cnt)) begin
            n_err++; $display("FAIL clr_last_update got=%0d exp=%0d", bus1.TOGGLE_CNT, exp_cnt);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        logic [7:0] last, w;
        exp_cnt = 0; last = 8'h00;
        bus2.OUT_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus2.A1 = (i % 2 == 0) ? 8'hFF : 8'h00;
            bus2.B1 = bus2.A1;
            bus2.A2 = 8'h00; bus2.B2 = 8'h00; bus2.MODE = 1'b0;
            bus2.IN_VALID = 1'b1;
            w = ref_zn(bus2.A1, 8'h00, bus2.B1, 8'h00, 1'b0);
            exp_cnt = exp_cnt + ham(last, w);
            if (exp_cnt > 15) exp_cnt = 15;
            last = w;
            @(posedge CK); #1;
            if (i == 2 || i == 4) begin
                bus2.IN_VALID = 1'b0;
                repeat (PD + 1) begin
                    @(posedge CK); #1;
                end
                n_checks++;
                if (bus2.TOGGLE_CNT !== 4'(exp_cnt)) begin
                    n_err++; $display("FAIL sat_cnt_after%0d got=%0d exp=%0d",
                                      i + 1, bus2.TOGGLE_CNT, exp_cnt);
                end
            end
        end
        bus2.IN_VALID = 1'b0;
    endtask

    task automatic test_reset_midstream();
        bus1.OUT_READY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus1.A1 = 8'($urandom); bus1.A2 = 8'($urandom);
            bus1.B1 = 8'($urandom); bus1.B2 = 8'($urandom);
            bus1.IN_VALID = 1'b1;
            @(posedge CK); #1;
        end
        bus1.IN_VALID = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if (bus1.OUT_VALID !== 1'b0) begin
            n_err++; $display("FAIL midrst_out_valid got=%b exp=0", bus1.OUT_VALID);
        end
        @(posedge CK); #1;
        RST = 1'b0;
        clear_q();
        push(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        run_stream(0);
        n_checks++;
        if (got.size() != 1 || got[0] !== exp_word(0)) begin
            n_err++; $display("FAIL midrst_first got n=%0d zn=%h exp n=1 zn=%h",
                              got.size(), (got.size() > 0) ? got[0] : 8'hxx, exp_word(0));
        end
        repeat (3) @(posedge CK);
        #1;
        n_checks++;
        if (bus1.OUT_VALID !== 1'b0) begin
            n_err++; $display("FAIL midrst_stale got ov=%b exp=0", bus1.OUT_VALID);
        end
    endtask

    initial begin
        RST = 1'b1;
        bus1.A1 = '0; bus1.A2 = '0; bus1.B1 = '0; bus1.B2 = '0; bus1.MODE = 1'b0;
        bus1.IN_VALID = 1'b0; bus1.OUT_READY = 1'b1; bus1.CLR = 1'b0;
        bus2.A1 = '0; bus2.A2 = '0; bus2.B1 = '0; bus2.B2 = '0; bus2.MODE = 1'b0;
        bus2.IN_VALID = 1'b0; bus2.OUT_READY = 1'b1; bus2.CLR = 1'b0;
        test_reset();
        test_truth(8'h0F, 8'h00, 8'h33, 8'h00, 1'b0, 8'hFC);
        test_truth(8'h0F, 8'hFF, 8'h33, 8'hFF, 1'b1, 8'hC0);
        test_sweep();
        test_backpressure();
        test_back_to_back();
        test_toggle_clr();
        test_saturation();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
